aes_decrypt128: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 §5.3): one 128-bit ciphertext block and one 128-bit key in, one plaintext block out, one round per clock. It is the receive-side counterpart of the AES-128 encrypt datapath. It reuses `KeyExpansion128` for the round-key schedule and adds the inverse round primitives (InvShiftRows, InvSubBytes, InvMixColumns) with a start/done handshake.

---
 rtl/aes_decrypt128.sv | 240 ++++++++++++++++++++++++
 tb/tb_aes_decrypt128.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt128.sv
// Iterative AES-128 inverse cipher, one round per clock, with start/done handshake.
// Optional feature: define AES_DEC_ABORT_EN to let start-while-busy abort and restart.

package aes_decrypt128_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 by square-and-multiply; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] t;
        t = gf_mul(gf_mul(x, x), x);
        t = gf_mul(gf_mul(t, t), x);
        t = gf_mul(gf_mul(t, t), x);
        t = gf_mul(gf_mul(t, t), x);
        t = gf_mul(gf_mul(t, t), x);
        t = gf_mul(gf_mul(t, t), x);
        return gf_mul(t, t);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        return gf_inv(y);
    endfunction

    // Byte i of a block lives at bits [8*i +: 8], row i%4, column i/4.
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c - r + 4) % 4)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[32*c + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

module KeyExpansion128
    import aes_decrypt128_pkg::*;
(
    input  logic [0:127]  key,
    output logic [0:1407] schedule
);

    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rcon;

    // Round key r occupies schedule[128*r +: 128], first word most significant.
    always_comb begin
        rcon = 8'h01;
        temp = 32'h0;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {sbox(temp[23:16]), sbox(temp[15:8]), sbox(temp[7:0]), sbox(temp[31:24])}
                       ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int i = 0; i < 44; i++) schedule[32*i +: 32] = w[i];
    end

endmodule

module aes_decrypt128
    import aes_decrypt128_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] cipher,
    input  logic [0:127] key,
    output logic [0:127] message,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [0:127] blk_q, blk_d;
    logic [0:127] key_q, key_d;
    logic [0:127] cipher_q, cipher_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [0:127] message_q, message_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [0:1407] sched;
    logic [0:127]  rk_round;

    KeyExpansion128 u_key_exp (
        .key      (key_q),
        .schedule (sched)
    );

    // Only round keys 1..9 are reachable from the ROUND update.
    always_comb begin
        rk_round = '0;
        for (int r = 1; r <= 9; r++) begin
            if (rnd_q == 4'(r)) rk_round = sched[128*r +: 128];
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        blk_d     = blk_q;
        key_d     = key_q;
        cipher_d  = cipher_q;
        rnd_d     = rnd_q;
        message_d = message_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (start) begin
                    key_d    = key;
                    cipher_d = cipher;
                    busy_d   = 1'b1;
                    fsm_d    = LOAD;
                end
            end
            LOAD: begin
                blk_d = cipher_q ^ sched[1280 +: 128];
                rnd_d = 4'd9;
                fsm_d = ROUND;
            end
            ROUND: begin
                blk_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_round);
                rnd_d = rnd_q - 4'd1;
                if (rnd_q <= 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                message_d = inv_sub_bytes(inv_shift_rows(blk_q)) ^ sched[0 +: 128];
                done_d    = 1'b1;
                busy_d    = 1'b0;
                fsm_d     = IDLE;
            end
            default: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
            end
        endcase

`ifdef AES_DEC_ABORT_EN
        // A restart discards the in-flight block without touching message or done.
        if (start && fsm_q != IDLE) begin
            key_d     = key;
            cipher_d  = cipher;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            message_d = message_q;
            fsm_d     = LOAD;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            blk_q     <= '0;
            key_q     <= '0;
            cipher_q  <= '0;
            rnd_q     <= '0;
            message_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            blk_q     <= blk_d;
            key_q     <= key_d;
            cipher_q  <= cipher_d;
            rnd_q     <= rnd_d;
            message_q <= message_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign message = message_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_aes_decrypt128.sv
// Self-checking bench for aes_decrypt128: known vectors, random blocks checked against
// a forward-cipher reference model, plus back-to-back, abort/ignore and reset sequences.

module tb_aes_decrypt128;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] cipher;
    logic [127:0] key;
    logic [127:0] message;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [127:0] last_msg = '0;
    logic [7:0]   sbox_t [256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] cipher;
        logic [127:0] expected;
    } vec_t;

    vec_t vecs [6];

    aes_decrypt128 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cipher  (cipher),
        .key     (key),
        .message (message),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Field multiply: carry-less product reduced by long division with 0x11B.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ ({8'h00, a} << i);
        end
        for (int bitpos = 14; bitpos >= 8; bitpos--) begin
            if (p[bitpos]) p = p ^ (16'h011b << (bitpos - 8));
        end
        return p[7:0];
    endfunction

    // Forward S-box from its definition: brute-force inverse, then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_t[x] = s;
        end
    endtask

    // Reference: forward AES-128 encryption; the DUT must invert it.
    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   w  [44][4];
        logic [7:0]   t  [4];
        logic [7:0]   st [16];
        logic [7:0]   nx [16];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i/4][i%4] = k[127-8*i -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                t = '{sbox_t[w[i-1][1]], sbox_t[w[i-1][2]], sbox_t[w[i-1][3]], sbox_t[w[i-1][0]]};
                t[0] = t[0] ^ rc;
                rc = m_mul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int b = 0; b < 16; b++) st[b] = pt[127-8*b -: 8] ^ w[b/4][b%4];
        for (int r = 1; r <= 10; r++) begin
            for (int b = 0; b < 16; b++) nx[b] = sbox_t[st[(b%4) + 4*(((b/4) + (b%4)) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = nx[4*c]; a1 = nx[4*c+1]; a2 = nx[4*c+2]; a3 = nx[4*c+3];
                    st[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
                    st[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
                end
            end else begin
                st = nx;
            end
            for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*r + b/4][b%4];
        end
        res = '0;
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; start is sampled on the following rising edge (E0).
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] c);
        start  = 1'b1;
        key    = k;
        cipher = c;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts falling edges from just after E0 until done is seen (n = edges elapsed).
    task automatic wait_done(input bit scramble, output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (scramble) begin
                cipher = rand128();
                key    = rand128();
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_and_check(input string name, input logic [127:0] k, input logic [127:0] c,
                                 input logic [127:0] exp, input bit scramble);
        int n;
        bit busy_ok;
        applyStimulus(k, c);
        wait_done(scramble, n, busy_ok);
        checkOutput({name, " latency"}, 128'(n), 128'(11));
        checkOutput({name, " busy in flight"}, 128'(busy_ok), 128'(1));
        checkOutput({name, " message"}, message, exp);
        checkOutput({name, " busy at done"}, 128'(busy), 128'(0));
        @(negedge clk);
        checkOutput({name, " done width"}, 128'(done), 128'(0));
        last_msg = exp;
    endtask

    initial begin
        int n;
        int n2;
        int extra;
        bit busy_ok;
        logic [127:0] pt;
        logic [127:0] k;
        logic [127:0] msg_at11;

        rst_n  = 1'b0;
        start  = 1'b0;
        cipher = '0;
        key    = '0;
        build_sbox();

        vecs[0] = '{"fips_b",  KEY_B, CT_B, PT_B};
        vecs[1] = '{"fips_c1", KEY_C, CT_C, PT_C};
        for (int i = 2; i < 6; i++) begin
            pt = rand128();
            k  = rand128();
            vecs[i] = '{$sformatf("vec%0d", i), k, model_encrypt(pt, k), pt};
        end

        repeat (3) @(negedge clk);
        checkOutput("reset busy", 128'(busy), 128'(0));
        checkOutput("reset done", 128'(done), 128'(0));
        checkOutput("reset message", message, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_and_check(vecs[i].name, vecs[i].key, vecs[i].cipher, vecs[i].expected, 1'b0);
        end

        // Back-to-back: second request issued in the done cycle of the first.
        applyStimulus(KEY_B, CT_B);
        wait_done(1'b0, n, busy_ok);
        checkOutput("b2b first latency", 128'(n), 128'(11));
        checkOutput("b2b first message", message, PT_B);
        applyStimulus(KEY_C, CT_C);
        wait_done(1'b0, n2, busy_ok);
        checkOutput("b2b done spacing", 128'(n2 + 1), 128'(12));
        checkOutput("b2b second message", message, PT_C);
        @(negedge clk);
        last_msg = PT_C;

        run_and_check("scrambled inputs", KEY_B, CT_B, PT_B, 1'b1);

        // start pulse sampled at E5 while a block is in flight.
        applyStimulus(KEY_B, CT_B);
        repeat (4) @(negedge clk);
`ifdef AES_DEC_ABORT_EN
        applyStimulus(KEY_C, CT_C);
        n = 5;
        msg_at11 = message;
        while (done !== 1'b1 && n < 40) begin
            if (n == 11) msg_at11 = message;
            @(negedge clk);
            n++;
        end
        checkOutput("abort latency", 128'(n), 128'(16));
        checkOutput("abort message", message, PT_C);
        checkOutput("abort old message kept", msg_at11, last_msg);
        last_msg = PT_C;
`else
        applyStimulus(rand128(), rand128());
        wait_done(1'b0, n, busy_ok);
        checkOutput("ignored start latency", 128'(n + 5), 128'(11));
        checkOutput("ignored start message", message, PT_B);
        last_msg = PT_B;
`endif
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checkOutput("mid-block start extra done", 128'(extra), 128'(0));

        // Reset asserted shortly after E6 of an in-flight block.
        applyStimulus(KEY_C, CT_C);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset busy", 128'(busy), 128'(0));
        checkOutput("async reset done", 128'(done), 128'(0));
        checkOutput("async reset message", message, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checkOutput("post reset quiet", 128'(extra), 128'(0));
        run_and_check("after reset", KEY_B, CT_B, PT_B, 1'b0);

        for (int i = 0; i < 12; i++) begin
            pt = rand128();
            k  = rand128();
            run_and_check($sformatf("random%0d", i), k, model_encrypt(pt, k), pt, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
